mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
Issue/sequencing controller between the core's RV32M execute stage and the iterative 32x32 byte-sliced multiplier. It accepts one request at a time through a valid/ready handshake and decodes funct3 into signed_A/signed_B/upper controls. It launches the multiplier, waits for its done flag (with timeout), and returns a tagged 32-bit result through a valid/ready response handshake. It also short-circuits zero-operand and illegal (divide-class) requests without occupying the multiplier.

Parameters:
TIMEOUT_CYCLES, 16, WAIT cycles allowed for mul_done_i before an error response; legal range 2..255.
TAG_W, 5, width of the request tag (destination register index).

Ports:
clk_i  input  1  clock; all logic on the rising edge
rst_i  input  1  reset, synchronous, active-high
req_valid_i  input  1  request valid
req_ready_o  output  1  controller can accept a request
req_funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx illegal here
req_op_a_i  input  32  operand rs1
req_op_b_i  input  32  operand rs2
req_tag_i  input  TAG_W  request tag
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  consumer accepts response
rsp_result_o  output  32  result
rsp_tag_o  output  TAG_W  echoed tag
rsp_err_o  output  1  1 = illegal funct3 or timeout
flush_i  input  1  pipeline flush; abort current operation
mul_start_o  output  1  one-cycle launch pulse to multiplier
mul_op_A_o  output  32  latched operand A
mul_op_B_o  output  32  latched operand B
mul_signed_A_o  output  1  decoded sign control A
mul_signed_B_o  output  1  decoded sign control B
mul_upper_o  output  1  decoded upper-half select
mul_result_i  input  32  multiplier result
mul_done_i  input  1  multiplier completion flag
busy_o  output  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high. State becomes IDLE. All registered outputs become 0: rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o, mul_start_o, mul_op_A_o, mul_op_B_o, all mul control bits, and the timeout counter.
- req_ready_o = (state==IDLE) & ~flush_i & ~rst_i (combinational). Reset mid-operation aborts with no response.
- Decode (latched at accept):
  - MUL: signed 0/0, upper 0.
  - MULH: signed 1/1, upper 1.
  - MULHSU: signed 1/0, upper 1.
  - MULHU: signed 0/0, upper 1.
- States:
  - IDLE: on req_valid_i & req_ready_o, latch operands, tag, decode.
    - funct3[2]=1: result 0, err 1, go RESP.
    - Else if op_a==0 or op_b==0: result 0, err 0, go RESP; the multiplier is not started.
    - Else go ISSUE.
  - ISSUE: mul_start_o=1 for exactly this cycle; clear counter; go WAIT. mul_op_*/control outputs stay stable from ISSUE until leaving WAIT.
  - WAIT: counter increments each cycle.
    - mul_done_i=1: capture mul_result_i, err 0, go RESP.
    - Else if counter==TIMEOUT_CYCLES-1: result 0, err 1, go RESP.
    - Done and timeout in the same cycle: done wins.
  - RESP: rsp_valid_o=1; result/tag/err held stable until rsp_ready_i. On rsp_valid_o & rsp_ready_i, go IDLE next cycle. No accept in the same cycle; minimum 1 idle cycle between operations.
- Latency:
  - Zero/illegal requests: response valid 1 cycle after accept.
  - Normal requests: mul_start_o 1 cycle after accept; response valid the cycle after mul_done_i is sampled.
- mul_done_i outside WAIT is ignored.
- flush_i:
  - In any state, the next state is IDLE, rsp_valid_o drops next cycle, and no response is produced for the aborted op.
  - A late mul_done_i after a flush is ignored.
  - Flush has priority over accept, done and timeout.
  - A flush in the ISSUE cycle still lets the start pulse occur that cycle; its result is discarded.
- rsp_result_o is unchanged by subsequent inputs while rsp_valid_o & ~rsp_ready_i.

Test Plan:
- MUL a=7, b=6, tag=3; stub multiplier asserts done 4 cycles after start with result 42 -> single mul_start_o pulse; signed 0/0, upper 0; rsp_result_o=42, tag 3, err 0.
- MULH a=0xFFFFFFFF, b=0x00000002; stub returns 0xFFFFFFFF -> signed 1/1, upper 1 during WAIT; rsp_result_o=0xFFFFFFFF. Repeat MULHSU -> 1/0/1, and MULHU -> 0/0/1.
- MULHSU a=0x12345678, b=0 -> no mul_start_o; rsp_valid_o the cycle after accept, result 0, err 0. funct3=3'b100 -> result 0, err 1, no start.
- Stub never asserts done, TIMEOUT_CYCLES=16 -> rsp_valid_o with err 1, result 0 after 16 WAIT cycles. Done asserted on the last WAIT cycle -> err 0, stub result returned.
- rsp_ready_i held low 5 cycles -> rsp_valid_o, result and tag constant; req_ready_o=0 throughout. A new request is accepted only after the handshake plus one cycle.
- flush_i in WAIT, then stub done 2 cycles later -> no response, busy_o=0, next request handled normally. rst_i asserted in RESP -> all outputs 0 next cycle; req_ready_o=0 while rst_i is high.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller between the RV32M execute stage and an iterative multiplier.
// Accepts one request at a time, launches the multiplier, waits (with timeout) and returns a tagged result.
module mul_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_op_a_i,
  input  logic [31:0]      req_op_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  input  logic             flush_i,
  output logic             mul_start_o,
  output logic [31:0]      mul_op_A_o,
  output logic [31:0]      mul_op_B_o,
  output logic             mul_signed_A_o,
  output logic             mul_signed_B_o,
  output logic             mul_upper_o,
  input  logic [31:0]      mul_result_i,
  input  logic             mul_done_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [31:0]      result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             signed_a_q, signed_a_d;
  logic             signed_b_q, signed_b_d;
  logic             upper_q, upper_d;
  logic             err_q, err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             start_q, start_d;
  logic             accept;

  assign req_ready_o = (state_q == S_IDLE) & ~flush_i & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    tag_d       = tag_q;
    signed_a_d  = signed_a_q;
    signed_b_d  = signed_b_q;
    upper_d     = upper_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    start_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d     = req_op_a_i;
          op_b_d     = req_op_b_i;
          tag_d      = req_tag_i;
          // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
          signed_a_d = ~req_funct3_i[2] & (req_funct3_i[1:0] == 2'b01 || req_funct3_i[1:0] == 2'b10);
          signed_b_d = ~req_funct3_i[2] & (req_funct3_i[1:0] == 2'b01);
          upper_d    = ~req_funct3_i[2] & (req_funct3_i[1:0] != 2'b00);
          if (req_funct3_i[2]) begin
            result_d    = '0;
            err_d       = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (req_op_a_i == '0 || req_op_b_i == '0) begin
            result_d    = '0;
            err_d       = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mul_done_i) begin
          result_d    = mul_result_i;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d    = '0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush outranks everything; the response registers keep their old contents.
    if (flush_i) begin
      state_d     = S_IDLE;
      rsp_valid_d = 1'b0;
      result_d    = result_q;
      err_d       = err_q;
      start_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      tag_q       <= '0;
      signed_a_q  <= 1'b0;
      signed_b_q  <= 1'b0;
      upper_q     <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      signed_a_q  <= signed_a_d;
      signed_b_q  <= signed_b_d;
      upper_q     <= upper_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      start_q     <= start_d;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_result_o   = result_q;
  assign rsp_tag_o      = tag_q;
  assign rsp_err_o      = err_q;
  assign mul_start_o    = start_q;
  assign mul_op_A_o     = op_a_q;
  assign mul_op_B_o     = op_b_q;
  assign mul_signed_A_o = signed_a_q;
  assign mul_signed_B_o = signed_b_q;
  assign mul_upper_o    = upper_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed and random requests against a stub
// multiplier, with expectations derived from the RV32M arithmetic definition.
module tb_mul_issue_ctrl;
  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic [4:0]  req_tag_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_tag_o;
  logic        rsp_err_o;
  logic        flush_i;
  logic        mul_start_o;
  logic [31:0] mul_op_A_o;
  logic [31:0] mul_op_B_o;
  logic        mul_signed_A_o;
  logic        mul_signed_B_o;
  logic        mul_upper_o;
  logic [31:0] mul_result_i = '0;
  logic        mul_done_i = 1'b0;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  int stub_delay = 0;
  int stub_cnt = 0;
  logic [31:0] stub_res;

  mul_issue_ctrl #(.TIMEOUT_CYCLES(TMO), .TAG_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o), .flush_i(flush_i),
    .mul_start_o(mul_start_o), .mul_op_A_o(mul_op_A_o), .mul_op_B_o(mul_op_B_o),
    .mul_signed_A_o(mul_signed_A_o), .mul_signed_B_o(mul_signed_B_o), .mul_upper_o(mul_upper_o),
    .mul_result_i(mul_result_i), .mul_done_i(mul_done_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Stub multiplier: computes from whatever operands/controls the controller presents,
  // raises done for one cycle stub_delay cycles after start (0 = never).
  always @(negedge clk_i) begin
    logic [65:0] sp;
    mul_done_i   = 1'b0;
    mul_result_i = $urandom;
    if (mul_start_o) begin
      sp = 66'($signed({mul_signed_A_o & mul_op_A_o[31], mul_op_A_o})) *
           66'($signed({mul_signed_B_o & mul_op_B_o[31], mul_op_B_o}));
      stub_res = mul_upper_o ? sp[63:32] : sp[31:0];
      stub_cnt = stub_delay;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        mul_done_i   = 1'b1;
        mul_result_i = stub_res;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // RV32M reference: 64-bit product of the architecturally extended operands.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    x = (f3 == 3'd1 || f3 == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
    y = (f3 == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
    p = x * y;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  // {signed_A, signed_B, upper} for each legal funct3
  function automatic logic [2:0] exp_ctrl(input logic [2:0] f3);
    case (f3)
      3'd0:    return 3'b000;
      3'd1:    return 3'b111;
      3'd2:    return 3'b101;
      default: return 3'b001;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int delay, input int hold);
    logic short_op, exp_err, stable;
    logic [31:0] exp_res;
    int lat, extra, exp_lat;
    short_op = f3[2] || a == 0 || b == 0;
    if (f3[2]) begin exp_res = 0; exp_err = 1; end
    else if (a == 0 || b == 0) begin exp_res = 0; exp_err = 0; end
    else if (delay >= 1 && delay <= TMO) begin exp_res = ref_mul(f3, a, b); exp_err = 0; end
    else begin exp_res = 0; exp_err = 1; end
    exp_lat = (delay >= 1 && delay <= TMO) ? delay + 1 : TMO + 1;

    @(negedge clk_i);
    stub_delay = delay;
    req_valid_i = 1; req_funct3_i = f3; req_op_a_i = a; req_op_b_i = b; req_tag_i = tag;
    rsp_ready_i = 0;
    #1;
    check("req_ready_idle", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 0; req_op_a_i = $urandom; req_op_b_i = $urandom;
    req_funct3_i = 3'($urandom); req_tag_i = 5'($urandom);
    if (short_op) begin
      check("short_rsp_latency", rsp_valid_o, 1);
      check("short_no_start", mul_start_o, 0);
    end else begin
      check("start_pulse", mul_start_o, 1);
      check("ctrl_decode", {mul_signed_A_o, mul_signed_B_o, mul_upper_o}, exp_ctrl(f3));
      check("op_a_latched", mul_op_A_o, a);
      check("op_b_latched", mul_op_B_o, b);
      lat = 0; extra = 0; stable = 1;
      while (!rsp_valid_o && lat < 40) begin
        @(negedge clk_i);
        lat++;
        extra += int'(mul_start_o);
        if (mul_op_A_o !== a || mul_op_B_o !== b ||
            {mul_signed_A_o, mul_signed_B_o, mul_upper_o} !== exp_ctrl(f3)) stable = 0;
      end
      check("single_start", extra, 0);
      check("ops_stable", stable, 1);
      check("rsp_latency", lat, exp_lat);
    end
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_result", rsp_result_o, exp_res);
    check("rsp_tag", rsp_tag_o, tag);
    check("rsp_err", rsp_err_o, exp_err);
    check("resp_busy_noready", {busy_o, req_ready_o}, 2'b10);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("hold_stable", {rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o, req_ready_o},
            {1'b1, exp_res, tag, exp_err, 1'b0});
    end
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    check("after_handshake", {rsp_valid_o, busy_o, req_ready_o}, 3'b001);
  endtask

  initial begin
    logic ok;
    logic [2:0] rf3;
    logic [31:0] ra, rb;
    int n;
    rst_i = 1; req_valid_i = 0; req_funct3_i = 0; req_op_a_i = 0; req_op_b_i = 0;
    req_tag_i = 0; rsp_ready_i = 0; flush_i = 0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_flags", {rsp_valid_o, rsp_err_o, rsp_tag_o, busy_o, mul_start_o,
                        mul_signed_A_o, mul_signed_B_o, mul_upper_o}, 0);
    check("rst_data", {rsp_result_o, mul_op_A_o}, 0);
    check("rst_op_b", mul_op_B_o, 0);
    rst_i = 0; #1;
    check("post_rst_ready", req_ready_o, 1);

    // Directed operations
    run_op(3'd0, 32'd7, 32'd6, 5'd3, 4, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd10, 3, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd11, 3, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd12, 3, 0);
    run_op(3'd2, 32'h1234_5678, 32'd0, 5'd13, 4, 0);
    run_op(3'd4, 32'd5, 32'd9, 5'd14, 4, 0);
    run_op(3'd0, 32'd5, 32'd9, 5'd15, 0, 0);           // never done -> timeout
    run_op(3'd3, 32'h8000_0001, 32'h7FFF_FFFF, 5'd16, TMO, 0);      // done on last WAIT cycle
    run_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd17, TMO + 1, 0);  // done one cycle too late
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd18, 1, 5);        // back-pressure

    // Flush beats a pending accept in IDLE
    @(negedge clk_i);
    req_valid_i = 1; req_funct3_i = 0; req_op_a_i = 3; req_op_b_i = 4; flush_i = 1; #1;
    check("flush_blocks_ready", req_ready_o, 0);
    @(negedge clk_i);
    req_valid_i = 0; flush_i = 0;
    check("flush_idle_no_accept", {busy_o, rsp_valid_o}, 2'b00);

    // Flush during WAIT, stub done arrives two cycles afterwards
    stub_delay = 4;
    req_valid_i = 1; req_funct3_i = 0; req_op_a_i = 3; req_op_b_i = 5; req_tag_i = 4;
    @(negedge clk_i);
    req_valid_i = 0;
    check("flush_wait_start", mul_start_o, 1);
    repeat (2) @(negedge clk_i);
    flush_i = 1;
    @(negedge clk_i);
    flush_i = 0;
    check("flush_wait_abort", {busy_o, rsp_valid_o}, 2'b00);
    ok = 1;
    repeat (6) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) ok = 0;
    end
    check("late_done_ignored", ok, 1);

    // Flush in the ISSUE cycle: pulse seen, nothing follows
    stub_delay = 2;
    req_valid_i = 1; req_funct3_i = 3; req_op_a_i = 9; req_op_b_i = 9;
    @(negedge clk_i);
    req_valid_i = 0;
    check("flush_issue_pulse", mul_start_o, 1);
    flush_i = 1;
    @(negedge clk_i);
    flush_i = 0;
    check("flush_issue_abort", {busy_o, rsp_valid_o, mul_start_o}, 3'b000);
    repeat (4) @(negedge clk_i);
    check("flush_issue_quiet", {busy_o, rsp_valid_o}, 2'b00);

    // Flush while a response is pending
    req_valid_i = 1; req_funct3_i = 3'd5; req_tag_i = 7;
    @(negedge clk_i);
    req_valid_i = 0;
    check("flush_resp_pending", rsp_valid_o, 1);
    flush_i = 1;
    @(negedge clk_i);
    flush_i = 0;
    check("flush_resp_drop", {rsp_valid_o, busy_o}, 2'b00);

    run_op(3'd0, 32'd11, 32'd13, 5'd21, 2, 1);          // normal after flushes

    // Reset while in RESP
    stub_delay = 2;
    req_valid_i = 1; req_funct3_i = 1; req_op_a_i = 5; req_op_b_i = 9; req_tag_i = 9;
    @(negedge clk_i);
    req_valid_i = 0;
    n = 0;
    while (!rsp_valid_o && n < 40) begin @(negedge clk_i); n++; end
    check("rr_reach_resp", rsp_valid_o, 1);
    rst_i = 1; #1;
    check("rr_ready_low", req_ready_o, 0);
    @(negedge clk_i);
    check("rr_flags", {rsp_valid_o, rsp_err_o, rsp_tag_o, busy_o, mul_start_o,
                       mul_signed_A_o, mul_signed_B_o, mul_upper_o}, 0);
    check("rr_data", {rsp_result_o, mul_op_A_o}, 0);
    check("rr_op_b", mul_op_B_o, 0);
    rst_i = 0;
    repeat (3) @(negedge clk_i);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      rf3 = ($urandom_range(0, 3) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      run_op(rf3, ra, rb, 5'($urandom), $urandom_range(0, 18), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
